dram_responder: RTL
===================

# dram_responder

Synthesizable memory-side responder for the accelerator's DRAM interface. It serves the read and write requests that layer engines such as the pooling and convolution blocks issue on `dram_en_rd`/`addr_in`/`data_in` and `dram_en_wr`/`addr_out`/`data_out`. It holds three memory banks: parameter, output feature map and input feature map. A host side-port preloads and inspects the banks while the layer engines are idle.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 18, engine address width.
- `BANK_AW`, 14, per-bank offset width; each bank holds 2^BANK_AW words.
- `READ_LATENCY`, 1, engine read latency in cycles; legal range 1–4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `srstn`  in  1  reset, asynchronous, active-low.
- `dram_en_rd`  in  1  engine read request, one word per cycle.
- `addr_in`  in  ADDR_WIDTH  engine read address.
- `dram_en_wr`  in  1  engine write request.
- `addr_out`  in  ADDR_WIDTH  engine write address.
- `data_out`  in  DATA_WIDTH  engine write data.
- `data_in`  out  DATA_WIDTH  engine read data.
- `dram_valid`  out  1  `data_in` carries the response to a read.
- `host_en`  in  1  host access request.
- `host_we`  in  1  host access is a write (1) or a read (0).
- `host_addr`  in  ADDR_WIDTH  host address.
- `host_wdata`  in  DATA_WIDTH  host write data.
- `host_ready`  out  1  host access accepted this cycle.
- `host_rdata`  out  DATA_WIDTH  host read data.
- `host_rvalid`  out  1  `host_rdata` valid.
- `err_oor`  out  1  sticky out-of-range flag.
- `err_addr`  out  ADDR_WIDTH  first offending address.

## Operation
Address decode, applied identically to engine and host addresses:
- Bank select is `addr[17:16]`:
  - 0 = PARAM (base 0)
  - 1 = OFMAP (base 65536)
  - 2 = IFMAP (base 131072)
  - 3 = out of range.
- Offset is `addr[BANK_AW-1:0]`.
- Bits `[15:BANK_AW]` nonzero means out of range.

Engine read:
- `dram_en_rd`=1 at cycle t with address A.
- At cycle t+READ_LATENCY, `data_in` = mem[A] and `dram_valid`=1.
- The read path is fully pipelined: one request per cycle and no back-pressure.
- Out-of-range read returns 0 with `dram_valid`=1.

Engine write:
- `dram_en_wr`=1 at cycle t writes `data_out` to mem[`addr_out`] at the edge ending cycle t.
- Out-of-range writes are dropped.

Read and write together:
- A read and a write may occur in the same cycle.
- Same address: the read returns the new data (write-first forwarding).
- A read issued after a write always observes that write.

Idle and hold behaviour:
- With no read in the slot, `dram_valid`=0 and `data_in` holds its last value.
- The held value is never forced to zero, because consumers shift `data_in` every cycle.

Host port:
- `host_ready` = ~`dram_en_rd` & ~`dram_en_wr` & (no engine read in flight).
- An access is accepted when `host_en` & `host_ready`.
- If `host_en` is high while `host_ready` is low, the request is ignored. The host holds its request until accepted.
- Accepted host read: `host_rdata` = mem and `host_rvalid`=1 exactly one cycle later, independent of READ_LATENCY. Out of range returns 0.
- Accepted host write: behaves as an engine write.

Errors:
- Any out-of-range access sets `err_oor`; this applies to engine read/write and accepted host accesses.
- `err_oor` stays set until reset.
- `err_addr` captures the address of the first offending access only.
- If a read and a write are both out of range in the same cycle, the read address is captured.

## Timing
- Reset values: `data_in`=0, `dram_valid`=0, `host_rdata`=0, `host_rvalid`=0, `err_oor`=0, `err_addr`=0.
- Memory contents are not reset.
- `host_ready` is combinational from the inputs and the in-flight state.
- Reset asserted mid-operation:
  - In-flight read responses are discarded; no `dram_valid` after release.
  - A write on the edge coinciding with reset assertion is not guaranteed.
- Engine read latency is exactly READ_LATENCY with no variation.
- Back-to-back reads give back-to-back `dram_valid`.
- Host read latency is 1 cycle.
- Bank 3 and high-bit violations take identical paths; no extra latency.

## Test plan
- PARAM load: host writes 10, 10, 16 to addresses 0, 1, 2. Engine reads 0, 1, 2 on consecutive cycles (READ_LATENCY=1) -> `data_in` = 10, 10, 16 on cycles t+1..t+3 with `dram_valid` high for all three.
- Pipelined IFMAP stream: 4 reads at 131072+{0,1,32,33} holding {5,9,3,7} -> 4 consecutive valid responses in order, then `dram_valid`=0 with `data_in` still 7.
- Forwarding: same-cycle write 0xDEAD to 65536 and read of 65536 (old value 0) -> read returns 0xDEAD.
- Out-of-range: read of 196608 -> `data_in`=0, `dram_valid`=1, `err_oor`=1, `err_addr`=196608. A later out-of-range write to 65536+2^14 leaves `err_addr` unchanged.
- Host arbitration: `host_en` held while engine reads for 3 cycles -> `host_ready`=0 until READ_LATENCY cycles after the last read. Then accepted; `host_rvalid` one cycle later.
- READ_LATENCY=3, reset mid-stream: 2 reads issued, `srstn` pulsed low before the responses -> no `dram_valid` after release; all outputs at reset values.

Source files
------------

// File: rtl/dram_responder.sv
// DRAM-side responder: three word banks (param, ofmap, ifmap) that serve engine reads with a
// fixed pipelined latency and engine writes, plus a host side-port used while the engines are idle.
module dram_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 18,
  parameter int BANK_AW      = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  dram_valid,
  input  logic                  host_en,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ready,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  err_oor,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int BANK_WORDS = 1 << BANK_AW;
  localparam logic [1:0] BANK_PARAM = 2'd0;
  localparam logic [1:0] BANK_OFMAP = 2'd1;
  localparam logic [1:0] BANK_IFMAP = 2'd2;

  logic [DATA_WIDTH-1:0] mem_param [BANK_WORDS];
  logic [DATA_WIDTH-1:0] mem_ofmap [BANK_WORDS];
  logic [DATA_WIDTH-1:0] mem_ifmap [BANK_WORDS];

  // Bank 3 and nonzero bits between the bank field and the offset are both out of range.
  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:BANK_AW] hi);
    return (hi[ADDR_WIDTH-1 -: 2] == 2'd3) || (|hi[ADDR_WIDTH-3:BANK_AW]);
  endfunction

  logic                  rd_oor;
  logic                  wr_oor;
  logic                  host_oor;
  logic                  in_flight;
  logic                  host_acc;
  logic                  host_rd_acc;
  logic                  wr_fire;
  logic [1:0]            wr_bank;
  logic [BANK_AW-1:0]    wr_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            lk_bank;
  logic [BANK_AW-1:0]    lk_off;
  logic [DATA_WIDTH-1:0] mem_word;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] host_word;
  logic                  pre_vld;
  logic [DATA_WIDTH-1:0] pre_dat;
  logic                  err_hit;
  logic [ADDR_WIDTH-1:0] err_src;

  assign rd_oor   = addr_oor(addr_in[ADDR_WIDTH-1:BANK_AW]);
  assign wr_oor   = addr_oor(addr_out[ADDR_WIDTH-1:BANK_AW]);
  assign host_oor = addr_oor(host_addr[ADDR_WIDTH-1:BANK_AW]);

  assign host_ready  = ~dram_en_rd & ~dram_en_wr & ~in_flight;
  assign host_acc    = host_en & host_ready;
  assign host_rd_acc = host_acc & ~host_we;

  // Host accesses only win when the engines are silent, so one write port and one lookup suffice.
  assign wr_fire = (dram_en_wr & ~wr_oor) | (host_acc & host_we & ~host_oor);
  assign wr_bank = dram_en_wr ? addr_out[ADDR_WIDTH-1 -: 2]  : host_addr[ADDR_WIDTH-1 -: 2];
  assign wr_off  = dram_en_wr ? addr_out[BANK_AW-1:0]        : host_addr[BANK_AW-1:0];
  assign wr_data = dram_en_wr ? data_out                     : host_wdata;

  assign lk_bank = dram_en_rd ? addr_in[ADDR_WIDTH-1 -: 2] : host_addr[ADDR_WIDTH-1 -: 2];
  assign lk_off  = dram_en_rd ? addr_in[BANK_AW-1:0]       : host_addr[BANK_AW-1:0];

  always_comb begin
    mem_word = '0;
    case (lk_bank)
      BANK_PARAM: mem_word = mem_param[lk_off];
      BANK_OFMAP: mem_word = mem_ofmap[lk_off];
      BANK_IFMAP: mem_word = mem_ifmap[lk_off];
      default:    mem_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      case (wr_bank)
        BANK_PARAM: mem_param[wr_off] <= wr_data;
        BANK_OFMAP: mem_ofmap[wr_off] <= wr_data;
        BANK_IFMAP: mem_ifmap[wr_off] <= wr_data;
        default: ;
      endcase
    end
  end

  // Write-first: a same-cycle write to the read address is forwarded into the read slot.
  assign fwd_hit   = dram_en_wr & ~wr_oor & (addr_out == addr_in);
  assign rd_word   = rd_oor ? '0 : (fwd_hit ? data_out : mem_word);
  assign host_word = host_oor ? '0 : mem_word;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign pre_vld   = dram_en_rd;
      assign pre_dat   = rd_word;
      assign in_flight = 1'b0;
    end else begin : g_latn
      logic [READ_LATENCY-2:0] sh_vld;
      logic [DATA_WIDTH-1:0]   sh_dat [READ_LATENCY-1];

      always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
          sh_vld <= '0;
          for (int i = 0; i < READ_LATENCY - 1; i++) sh_dat[i] <= '0;
        end else begin
          sh_vld[0] <= dram_en_rd;
          sh_dat[0] <= rd_word;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            sh_vld[i] <= sh_vld[i-1];
            sh_dat[i] <= sh_dat[i-1];
          end
        end
      end

      assign pre_vld   = sh_vld[READ_LATENCY-2];
      assign pre_dat   = sh_dat[READ_LATENCY-2];
      assign in_flight = |sh_vld;
    end
  endgenerate

  // data_in only moves on a response; downstream shifters rely on the held value.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      data_in    <= '0;
      dram_valid <= 1'b0;
    end else begin
      dram_valid <= pre_vld;
      if (pre_vld) data_in <= pre_dat;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_rd_acc;
      if (host_rd_acc) host_rdata <= host_word;
    end
  end

  assign err_hit = (dram_en_rd & rd_oor) | (dram_en_wr & wr_oor) | (host_acc & host_oor);
  assign err_src = (dram_en_rd & rd_oor) ? addr_in :
                   (dram_en_wr & wr_oor) ? addr_out : host_addr;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      err_oor  <= 1'b0;
      err_addr <= '0;
    end else if (!err_oor && err_hit) begin
      err_oor  <= 1'b1;
      err_addr <= err_src;
    end
  end

endmodule
